// File: rtl/decrypt_pkg.sv
// Shared definitions for the decrypt block: key-schedule state encoding and
// the default symbol width.
package decrypt_pkg;

  localparam int unsigned DEFAULT_N = 7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    KSA  = 2'd2,
    RUN  = 2'd3
  } state_e;

endpackage

// File: rtl/rc4_keystream.sv
// RC4-style keystream generator over N-bit symbols. Owns the S-box, the i/j
// indices and the FILL -> KSA -> RUN sequencing. ks_word is the keystream
// word the next advance will consume; advance commits that step.
module rc4_keystream
  import decrypt_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] key,
  input  logic         advance,
  output logic [N-1:0] ks_word,
  output logic         ks_ready
);

  localparam int unsigned  DEPTH    = 1 << N;
  localparam logic [N-1:0] IDX_LAST = '1;

  state_e       state_q;
  logic [N-1:0] i_q;
  logic [N-1:0] j_q;
  logic [N-1:0] sbox_q [DEPTH];

  logic [N-1:0] i_inc;
  logic [N-1:0] s_i;
  logic [N-1:0] j_ksa;
  logic [N-1:0] s_inc;
  logic [N-1:0] j_run;
  logic [N-1:0] s_jrun;
  logic [N-1:0] t_idx;

  // Index arithmetic for the current state; the keystream word is read from
  // the S-box as it will look after this step's swap.
  always_comb begin
    // NOTE: every branch of ks_word is covered and the rest are plain
    // assignments, so no latch can be inferred from this block.
    i_inc  = i_q + N'(1);
    s_i    = sbox_q[i_q];
    j_ksa  = j_q + s_i + key;
    s_inc  = sbox_q[i_inc];
    j_run  = j_q + s_inc;
    s_jrun = sbox_q[j_run];
    t_idx  = s_inc + s_jrun;
    if (t_idx == i_inc) begin
      ks_word = s_jrun;
    end else if (t_idx == j_run) begin
      ks_word = s_inc;
    end else begin
      ks_word = sbox_q[t_idx];
    end
  end

  assign ks_ready = (state_q == RUN);

  // Key-schedule sequencer: start from any state restarts at FILL.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: non-blocking assignments keep every register update tied to the
    // edge, so the order of statements never changes behaviour.
    if (!rst) begin
      state_q <= IDLE;
      i_q     <= '0;
      j_q     <= '0;
    end else if (start) begin
      state_q <= FILL;
      i_q     <= '0;
      j_q     <= '0;
    end else begin
      case (state_q)
        FILL: begin
          i_q <= i_inc;
          if (i_q == IDX_LAST) state_q <= KSA;
        end
        KSA: begin
          i_q <= i_inc;
          j_q <= j_ksa;
          if (i_q == IDX_LAST) begin
            state_q <= RUN;
            j_q     <= '0;
          end
        end
        RUN: begin
          if (advance) begin
            i_q <= i_inc;
            j_q <= j_run;
          end
        end
        default: ;
      endcase
    end
  end

  // S-box storage: identity fill, key-schedule swaps and stream swaps.
  always_ff @(posedge clk) begin
    // NOTE: the S-box deliberately has no reset; FILL rewrites every entry
    // before any read can matter, which keeps it mappable to plain storage.
    case (state_q)
      FILL: sbox_q[i_q] <= i_q;
      KSA: begin
        sbox_q[i_q]   <= sbox_q[j_ksa];
        sbox_q[j_ksa] <= s_i;
      end
      RUN: begin
        if (advance) begin
          sbox_q[i_inc] <= s_jrun;
          sbox_q[j_run] <= s_inc;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/decrypt.sv
// Stream decryptor: latches the password, drives the keystream generator and
// XORs each accepted ciphertext symbol into a one-deep output register with
// valid/ready handshaking. Defining DECRYPT_CNT_EN adds the sym_cnt output
// counting output handshakes.
module decrypt
  import decrypt_pkg::*;
#(
  parameter int unsigned N = DEFAULT_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] password,
  input  logic         in_valid,
  input  logic [N-1:0] data_in,
  output logic         in_ready,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] data_out,
  output logic         init_done
`ifdef DECRYPT_CNT_EN
  ,
  output logic [15:0]  sym_cnt
`endif
);

  logic [N-1:0] key_q;
  logic [N-1:0] data_q;
  logic         valid_q;
  logic [N-1:0] ks_word;
  logic         ks_ready;
  logic         accept;

  assign init_done = ks_ready;
  assign in_ready  = ks_ready & (~valid_q | out_ready);
  // A start in the same cycle aborts the stream, so it also vetoes the accept.
  assign accept    = in_valid & in_ready & ~start;
  assign data_out  = data_q;
  assign out_valid = valid_q;

  rc4_keystream #(
    .N (N)
  ) u_keystream (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .key      (key_q),
    .advance  (accept),
    .ks_word  (ks_word),
    .ks_ready (ks_ready)
  );

  // Key latch and output register: start drops any pending symbol.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
    end else if (start) begin
      key_q   <= password;
      valid_q <= 1'b0;
    end else if (accept) begin
      data_q  <= data_in ^ ks_word;
      valid_q <= 1'b1;
    end else if (out_ready) begin
      valid_q <= 1'b0;
    end
  end

`ifdef DECRYPT_CNT_EN
  logic [15:0] cnt_q;

  // Output handshake counter, cleared by start and wrapping at 16 bits.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else if (start) begin
      cnt_q <= '0;
    end else if (valid_q && out_ready) begin
      cnt_q <= cnt_q + 16'd1;
    end
  end

  assign sym_cnt = cnt_q;
`endif

endmodule

// File: doc/decrypt.md
DECRYPT -- requirements
Module: decrypt

Interface
REQ-001 Parameter N, default 7, SHALL set symbol width; S-box depth is 2^N entries of N bits.
REQ-002 clk  input  1  sole clock, all state on rising edge.
REQ-003 rst  input  1  asynchronous, active-low reset.
REQ-004 start  input  1  one-cycle pulse; latches password and begins key setup.
REQ-005 password  input  N  key word, sampled only on the edge that accepts start.
REQ-006 in_valid  input  1  ciphertext symbol present on data_in.
REQ-007 data_in  input  N  ciphertext symbol.
REQ-008 in_ready  output  1  block accepts data_in this cycle.
REQ-009 out_valid  output  1  data_out holds a plaintext symbol.
REQ-010 out_ready  input  1  downstream accepts data_out.
REQ-011 data_out  output  N  plaintext = ciphertext XOR keystream word.
REQ-012 init_done  output  1  key setup complete, stream phase active.

Function
REQ-013 States SHALL be IDLE, FILL, KSA, RUN.
REQ-014 IDLE: start -> FILL, with i=0, j=0 and password latched into key register.
REQ-015 FILL: S[i]=i, one entry per cycle, 2^N cycles, then KSA with i=0.
REQ-016 KSA: one iteration per cycle, j=(j+S[i]+key) mod 2^N, swap S[i],S[j], 2^N cycles, then RUN with i=0, j=0.
REQ-017 init_done SHALL be 1 only in RUN, first asserted exactly 2^(N+1) edges after the edge accepting start (256 for N=7).
REQ-018 in_ready = init_done AND (NOT out_valid OR out_ready), combinational.
REQ-019 Accept (in_valid AND in_ready): i'=i+1, j'=j+S[i'], swap S[i'],S[j'], K=S[(S[i']+S[j']) mod 2^N]; data_out<=data_in XOR K; out_valid<=1; latency one cycle.
REQ-020 Keystream SHALL advance only on accept; no symbol is skipped or repeated under any stall pattern.
REQ-021 data_out and out_valid SHALL hold stable while out_valid AND NOT out_ready.
REQ-022 out_valid clears on out_ready without a simultaneous accept; simultaneous accept and drain SHALL sustain one symbol per cycle.
REQ-023 All index arithmetic SHALL wrap modulo 2^N; i wraps 2^N-1 -> 0 silently.
REQ-024 start in any non-IDLE state SHALL abort, drop any pending output (out_valid<=0), relatch password, re-enter FILL.
REQ-025 in_valid while not in RUN SHALL be ignored (in_ready=0).

Reset
REQ-026 rst low SHALL force IDLE, i=j=0, key=0, data_out=0, out_valid=0, init_done=0, in_ready=0, mid-operation included.
REQ-027 S-box contents need no reset; FILL rewrites every entry before use.

Configuration
REQ-028 DECRYPT_CNT_EN defined: add output sym_cnt [15:0], counting output handshakes (out_valid AND out_ready), reset to 0 and on start, wrapping 16'hFFFF -> 0.
REQ-029 DECRYPT_CNT_EN undefined: port and counter SHALL not exist; all other behaviour identical.

Structure
REQ-030 Shared package SHALL hold the state enum (IDLE, FILL, KSA, RUN) and default width constant 7.
REQ-031 S-box, i/j registers and FILL/KSA/PRGA sequencing SHALL live in sub-module rc4_keystream (ports: clk, rst, start, key, advance, ks_word, ks_ready); decrypt holds the handshake, key latch and XOR.

Verification
REQ-032 Reset: rst low mid-KSA -> next cycle init_done=0, out_valid=0, data_out=0; after release block idles until start.
REQ-033 Setup timing: start with password 7'h15 -> init_done rises exactly 256 edges later, in_ready=0 throughout.
REQ-034 Round trip: 64 symbols 7'h00..7'h3F encrypted by golden model keyed 7'h15, fed back-to-back with out_ready=1 -> plaintext 7'h00..7'h3F, one per cycle, latency 1.
REQ-035 Backpressure: out_ready random 30% duty, in_valid random -> same plaintext sequence, data_out stable while stalled, no loss or duplication.
REQ-036 Restart: start with 7'h2A after 10 symbols -> pending output dropped, init_done low 256 edges, next symbols match keystream of 7'h2A from index 0.
REQ-037 With DECRYPT_CNT_EN: 70000 drained symbols -> sym_cnt = 70000 mod 65536 = 4464.
